// File: rtl/wb_memtest_pkg.sv
// Shared types and constants for the Wishbone memory pattern tester.
// Latency: n/a (types, constants and elaboration-time helper functions only).
// Backpressure: n/a.
// Contents: FSM state encoding, address-width helper, Galois LFSR tap masks per data width.
package wb_memtest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WREQ,
      ST_WACK,
      ST_RREQ,
      ST_RACK,
      ST_DONE
   } state_t;

   // Word address width: byte address width minus the byte-lane bits.
   function automatic int addr_bits(input int arch);
      return arch - $clog2(arch / 8);
   endfunction

   // Right-shifting Galois feedback masks (bit n-1 set means x^n term).
   function automatic logic [255:0] lfsr_taps(input int width);
      logic [255:0] t;
      t = '0;
      case (width)
         32: begin
            t[31] = 1'b1; t[21] = 1'b1; t[1] = 1'b1; t[0] = 1'b1;
         end
         64: begin
            t[63] = 1'b1; t[62] = 1'b1; t[60] = 1'b1; t[59] = 1'b1;
         end
         128: begin
            t[127] = 1'b1; t[125] = 1'b1; t[100] = 1'b1; t[98] = 1'b1;
         end
         256: begin
            t[255] = 1'b1; t[253] = 1'b1; t[250] = 1'b1; t[245] = 1'b1;
         end
         default: begin
            t[15] = 1'b1; t[13] = 1'b1; t[12] = 1'b1; t[10] = 1'b1;
         end
      endcase
      return t;
   endfunction

endpackage

// File: rtl/wb_memtest_if.sv
// Wishbone request/response bundle between the pattern tester and a memory slave.
// Latency: n/a (wires only).
// Backpressure: slave stalls a presented request with bsy; completion signalled by ack.
// Ports: master drives cyc/stb/we/addr/sel/dat_m; slave drives bsy/ack/dat_s.
interface wb_memtest_if
   import wb_memtest_pkg::*;
#(
   parameter int ARCHBITSZ = 16
);
   localparam int ADDRBITSZ = addr_bits(ARCHBITSZ);

   logic                   cyc;
   logic                   stb;
   logic                   we;
   logic [ADDRBITSZ-1:0]   addr;
   logic [ARCHBITSZ/8-1:0] sel;
   logic [ARCHBITSZ-1:0]   dat_m;
   logic [ARCHBITSZ-1:0]   dat_s;
   logic                   bsy;
   logic                   ack;

   modport master (output cyc, stb, we, addr, sel, dat_m, input bsy, ack, dat_s);
   modport slave  (input cyc, stb, we, addr, sel, dat_m, output bsy, ack, dat_s);

endinterface

// File: rtl/wb_memtest_lfsr.sv
// Galois LFSR generating the write/expected-read data sequence.
// Latency: new state visible one cycle after load or step.
// Backpressure: none; holds state when neither load nor step is asserted.
// Ports: clk_i/rstn_i, load (seed in, 0 replaced by 1), step (advance one state), state (current word).
module wb_memtest_lfsr
   import wb_memtest_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] state
);

   localparam logic [255:0]     TAPS_ALL = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state <= WIDTH'(1);
      end else if (load) begin
         // An all-zero state would lock the register, so a zero seed becomes 1.
         state <= (seed == '0) ? WIDTH'(1) : seed;
      end else if (step) begin
         state <= (state >> 1) ^ (state[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/wb_memtest.sv
// Wishbone initiator: writes an LFSR pattern over a word range, reads it back and compares.
// Latency: zero-wait slave gives 2 cycles/word per phase; done_o 4*cnt+2 edges after start_i.
// Backpressure: one outstanding access; holds request while bsy, aborts after TIMEOUT idle cycles.
// Ports: clk_i/rstn_i; start_i/base_i/cnt_i/seed_i in; busy/done/pass/timeout/errcnt/erraddr out; wb master.
module wb_memtest
   import wb_memtest_pkg::*;
#(
   parameter  int ARCHBITSZ = 16,
   parameter  int TIMEOUT   = 1024,
   localparam int ADDRBITSZ = addr_bits(ARCHBITSZ)
)
(
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 start_i,
   input  logic [ADDRBITSZ-1:0] base_i,
   input  logic [ADDRBITSZ-1:0] cnt_i,
   input  logic [ARCHBITSZ-1:0] seed_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic                 timeout_o,
   output logic [ADDRBITSZ-1:0] errcnt_o,
   output logic [ADDRBITSZ-1:0] erraddr_o,
   wb_memtest_if.master         wb
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t               state, state_nxt;
   logic [ADDRBITSZ-1:0] base_q, cnt_q, addr_q, left_q;
   logic [ADDRBITSZ-1:0] errcnt_q, erraddr_q;
   logic [ARCHBITSZ-1:0] seed_q, lfsr_q;
   logic [TW-1:0]        tcnt_q;
   logic                 busy_q, done_q, pass_q, timeout_q;
   logic                 cyc, stb, we;
   logic                 start_ok, accept, ack_ev, last, tmo;
   logic                 lfsr_load, lfsr_step;

   assign start_ok = (state == ST_IDLE) && start_i;
   assign accept   = stb && !wb.bsy;
   assign ack_ev   = ((state == ST_WACK) || (state == ST_RACK)) && wb.ack;
   assign last     = (left_q == ADDRBITSZ'(1));

   // Counts cycles since the last accept/ack; only grows while stalled or awaiting ack.
   generate
      if (TIMEOUT == 0) begin : g_no_tmo
         assign tmo = 1'b0;
      end else begin : g_tmo
         assign tmo = cyc && !accept && !ack_ev && (tcnt_q == TW'(TIMEOUT - 1));
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (!rstn_i) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_i) state_nxt = (cnt_i == '0) ? ST_DONE : ST_WREQ;
         ST_WREQ: if (tmo) state_nxt = ST_DONE; else if (accept) state_nxt = ST_WACK;
         ST_WACK: if (tmo) state_nxt = ST_DONE; else if (wb.ack) state_nxt = last ? ST_RREQ : ST_WREQ;
         ST_RREQ: if (tmo) state_nxt = ST_DONE; else if (accept) state_nxt = ST_RACK;
         ST_RACK: if (tmo) state_nxt = ST_DONE; else if (wb.ack) state_nxt = last ? ST_DONE : ST_RREQ;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
      case (state)
         ST_WREQ: begin cyc = 1'b1; stb = 1'b1; we = 1'b1; end
         ST_WACK: begin cyc = 1'b1; we = 1'b1; end
         ST_RREQ: begin cyc = 1'b1; stb = 1'b1; end
         ST_RACK: cyc = 1'b1;
         default: ;
      endcase
   end

   // Word i carries the LFSR state after i steps; the read phase replays from the seed.
   assign lfsr_load = start_ok || (ack_ev && (state == ST_WACK) && last);
   assign lfsr_step = ack_ev && !((state == ST_WACK) && last);

   wb_memtest_lfsr #(.WIDTH(ARCHBITSZ)) u_lfsr (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .load   (lfsr_load),
      .step   (lfsr_step),
      .seed   (start_ok ? seed_i : seed_q),
      .state  (lfsr_q)
   );

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         base_q    <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         left_q    <= '0;
         seed_q    <= '0;
         errcnt_q  <= '0;
         erraddr_q <= '0;
         tcnt_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         done_q <= (state == ST_DONE);
         if (start_ok || accept || ack_ev) tcnt_q <= '0;
         else if (cyc)                     tcnt_q <= tcnt_q + 1'b1;

         if (start_ok) begin
            base_q    <= base_i;
            cnt_q     <= cnt_i;
            addr_q    <= base_i;
            left_q    <= cnt_i;
            seed_q    <= seed_i;
            errcnt_q  <= '0;
            erraddr_q <= '0;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
         end

         if (state == ST_DONE) begin
            busy_q <= 1'b0;
            pass_q <= (errcnt_q == '0) && !timeout_q;
         end

         if (tmo) begin
            timeout_q <= 1'b1;
            erraddr_q <= addr_q;
         end else if (ack_ev) begin
            if (last) begin
               addr_q <= base_q;
               left_q <= cnt_q;
            end else begin
               addr_q <= addr_q + 1'b1;
               left_q <= left_q - 1'b1;
            end
            if ((state == ST_RACK) && (wb.dat_s != lfsr_q)) begin
               // Count saturates, so it never returns to zero and erraddr latches once.
               if (errcnt_q == '0) erraddr_q <= addr_q;
               if (errcnt_q != '1) errcnt_q  <= errcnt_q + 1'b1;
            end
         end
      end
   end

   assign wb.cyc   = cyc;
   assign wb.stb   = stb;
   assign wb.we    = we;
   assign wb.addr  = addr_q;
   assign wb.sel   = '1;
   assign wb.dat_m = lfsr_q;

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign pass_o    = pass_q;
   assign timeout_o = timeout_q;
   assign errcnt_o  = errcnt_q;
   assign erraddr_o = erraddr_q;

endmodule

// File: tb/tb_wb_memtest.sv
// Testbench for wb_memtest: memory slave model with bsy/ack delays, directed and random runs.
// Latency: n/a.
// Backpressure: slave model stalls with bsy and delays ack per the knobs below.
module tb_wb_memtest;
   localparam int AW  = 15;
   localparam int DW  = 16;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rstn, start;
   logic [AW-1:0] base, cnt;
   logic [DW-1:0] seed;
   logic          busy, done, pass, tmo_flag;
   logic [AW-1:0] errcnt, erraddr;

   wb_memtest_if #(.ARCHBITSZ(DW)) wbi ();

   wb_memtest #(.ARCHBITSZ(DW), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .base_i(base), .cnt_i(cnt),
      .seed_i(seed), .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo_flag),
      .errcnt_o(errcnt), .erraddr_o(erraddr), .wb(wbi)
   );

   always #5 clk = ~clk;

   // Slave model knobs (written only by the main initial block).
   int            bsy_dly = 0, ack_dly = 0;
   bit            rnd = 0, no_ack = 0, bsy_forever = 0, corrupt_en = 0;
   logic [AW-1:0] ctrig = '0, ca1 = '0, ca2 = '0;

   // Slave model state and logs.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            bcnt = 0, acnt = 0, cur_bdly = 0, cur_adly = 0, adly_now;
   bit            pending = 0;
   logic [AW-1:0] paddr = '0;
   logic [AW-1:0] wr_a[$];
   logic [DW-1:0] wr_d[$];
   int            rd_n = 0, cyc_n = 0, stb_n = 0, done_n = 0, viol = 0;

   int checks = 0, errors = 0;

   assign adly_now = rnd ? cur_adly : ack_dly;
   assign wbi.bsy  = wbi.cyc & wbi.stb & (bsy_forever | ((rnd ? cur_bdly : bsy_dly) > bcnt));

   always @(posedge clk) begin
      wbi.ack <= 1'b0;
      if (!rstn || !wbi.cyc) begin
         pending <= 1'b0;
         bcnt    <= 0;
      end else begin
         if (pending && acnt == 0) begin
            wbi.ack   <= 1'b1;
            wbi.dat_s <= mem[paddr];
            pending   <= 1'b0;
         end else if (pending) begin
            acnt <= acnt - 1;
         end
         if (wbi.stb && wbi.bsy) begin
            bcnt <= bcnt + 1;
         end else if (wbi.stb) begin
            bcnt     <= 0;
            cur_bdly <= int'($urandom_range(0, 3));
            cur_adly <= int'($urandom_range(0, 3));
            if (wbi.we) begin
               mem[wbi.addr] <= wbi.dat_m;
               wr_a.push_back(wbi.addr);
               wr_d.push_back(wbi.dat_m);
            end else begin
               rd_n <= rd_n + 1;
               // Corrupt stored words just as the read phase begins.
               if (corrupt_en && wbi.addr == ctrig) begin
                  mem[ca1] <= mem[ca1] ^ 16'h0100;
                  mem[ca2] <= mem[ca2] ^ 16'h0010;
               end
            end
            if (!no_ack) begin
               if (adly_now == 0) begin
                  wbi.ack   <= 1'b1;
                  wbi.dat_s <= mem[wbi.addr];
               end else begin
                  pending <= 1'b1;
                  paddr   <= wbi.addr;
                  acnt    <= adly_now - 1;
               end
            end
         end
      end
   end

   // Bus monitor: activity counters and request-stability / select rules.
   logic          prev_hold = 1'b0, p_we = 1'b0;
   logic [AW-1:0] p_addr = '0;
   logic [DW-1:0] p_dat = '0;
   always @(negedge clk) begin
      if (wbi.cyc) cyc_n <= cyc_n + 1;
      if (wbi.stb) stb_n <= stb_n + 1;
      if (done)    done_n <= done_n + 1;
      if ((wbi.stb && !wbi.cyc) || (wbi.cyc && wbi.sel != 2'b11) ||
          (prev_hold && wbi.stb && (wbi.addr != p_addr || wbi.dat_m != p_dat || wbi.we != p_we)))
         viol <= viol + 1;
      prev_hold <= wbi.stb & wbi.bsy;
      p_addr    <= wbi.addr;
      p_dat     <= wbi.dat_m;
      p_we      <= wbi.we;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference sequence: word i is the seed advanced i times by the x^16+x^14+x^13+x^11+1 Galois map.
   function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
      if (x % 2 == 1) return (x / 2) ^ 16'hB400;
      return x / 2;
   endfunction

   int wr0, rd0, cyc0, stb0, done0, viol0, lat;

   task automatic snap();
      wr0 = wr_a.size(); rd0 = rd_n; cyc0 = cyc_n; stb0 = stb_n; done0 = done_n; viol0 = viol;
   endtask

   // Starts a test (caller sits at a negedge) and waits for done_o with a cycle budget.
   task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] c, input logic [DW-1:0] s,
                      input int glitch, output int l);
      snap();
      base = b; cnt = c; seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      base = AW'($urandom); cnt = AW'($urandom); seed = DW'($urandom);
      l = 1;
      chk("busy_after_start", busy, 1);
      while (!done && l < 3000) begin
         if (l == glitch) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         l++;
      end
      chk("done_seen", done, 1);
   endtask

   // After done: pulse is one cycle, then check logged writes and bus activity.
   task automatic post(input logic [AW-1:0] b, input int c, input logic [DW-1:0] s, input int exp_cyc);
      logic [DW-1:0] x;
      int bad;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_cleared", busy, 0);
      @(negedge clk);
      chk("done_pulses", done_n - done0, 1);
      chk("protocol", viol - viol0, 0);
      chk("wr_count", wr_a.size() - wr0, c);
      chk("rd_count", rd_n - rd0, c);
      if (exp_cyc >= 0) begin
         chk("cyc_cycles", cyc_n - cyc0, exp_cyc);
      end
      x = (s == '0) ? 16'h0001 : s;
      bad = 0;
      for (int i = 0; i < c && wr0 + i < wr_a.size(); i++) begin
         if (wr_a[wr0 + i] != AW'(int'(b) + i) || wr_d[wr0 + i] != x) bad++;
         x = lfsr_next(x);
      end
      chk("wr_pattern", bad, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] b, c;
      logic [DW-1:0] s;
      rstn = 1'b0; start = 1'b0; base = '0; cnt = '0; seed = '0;
      repeat (3) @(negedge clk);
      chk("rst_cyc", wbi.cyc, 0);
      chk("rst_busy", busy, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_outputs", {busy, done, pass, tmo_flag, wbi.cyc, wbi.stb}, 0);
      chk("idle_err", {errcnt, erraddr}, 0);

      // Zero-wait slave, 16 words from address 0.
      run(15'h0, 15'd16, 16'h0001, -1, lat);
      chk("t1_latency", lat, 66);
      chk("t1_pass", {pass, tmo_flag, errcnt}, {1'b1, 1'b0, 15'd0});
      post(15'h0, 16, 16'h0001, 64);
      chk("t1_stb_once", stb_n - stb0, 32);

      // Ack delayed 3 cycles: stb one cycle per access, cyc held until ack.
      ack_dly = 3;
      s = DW'($urandom);
      run(15'h40, 15'd8, s, -1, lat);
      chk("t2_latency", lat, 82);
      chk("t2_pass", {pass, tmo_flag, errcnt}, {1'b1, 1'b0, 15'd0});
      post(15'h40, 8, s, 80);
      chk("t2_stb_once", stb_n - stb0, 16);
      ack_dly = 0;

      // Random bsy stalls and ack delays.
      rnd = 1;
      for (int k = 0; k < 4; k++) begin
         b = AW'($urandom);
         c = AW'($urandom_range(1, 20));
         s = DW'($urandom);
         run(b, c, s, -1, lat);
         chk("rnd_pass", {pass, tmo_flag, errcnt}, {1'b1, 1'b0, 15'd0});
         post(b, int'(c), s, -1);
      end
      rnd = 0;

      // One corrupted word (base 4, word 5 -> address 9).
      corrupt_en = 1; ctrig = 15'd4; ca1 = 15'd9; ca2 = 15'd9;
      run(15'd4, 15'd8, 16'hACE1, -1, lat);
      chk("t3_errcnt", errcnt, 1);
      chk("t3_erraddr", erraddr, 9);
      chk("t3_pass_tmo", {pass, tmo_flag}, 2'b00);
      post(15'd4, 8, 16'hACE1, 32);

      // Two corrupted words: first in read order is latched.
      ca1 = 15'd9; ca2 = 15'd6;
      run(15'd4, 15'd8, 16'h1234, -1, lat);
      chk("t3b_errcnt", errcnt, 2);
      chk("t3b_erraddr", erraddr, 6);
      chk("t3b_pass", pass, 0);
      post(15'd4, 8, 16'h1234, 32);
      corrupt_en = 0;

      // Slave never acknowledges.
      no_ack = 1;
      run(15'h123, 15'd5, 16'h0077, -1, lat);
      chk("t4_latency", lat, TMO + 3);
      chk("t4_timeout", tmo_flag, 1);
      chk("t4_erraddr", erraddr, 15'h123);
      chk("t4_pass", pass, 0);
      chk("t4_cyc_low", wbi.cyc, 0);
      @(negedge clk);
      no_ack = 0;

      // Slave holds bsy forever.
      bsy_forever = 1;
      run(15'h200, 15'd3, 16'h0005, -1, lat);
      chk("t4b_timeout", tmo_flag, 1);
      chk("t4b_erraddr", erraddr, 15'h200);
      chk("t4b_pass", pass, 0);
      @(negedge clk);
      bsy_forever = 0;

      // Reset during the write phase.
      snap();
      base = 15'h10; cnt = 15'd16; seed = 16'h00F0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("t5_cyc_mid_write", {wbi.cyc, wbi.we}, 2'b11);
      rstn = 1'b0;
      @(negedge clk);
      chk("t5_reset_bus", {wbi.cyc, wbi.stb, busy, done}, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      chk("t5_no_done", done_n - done0, 0);
      run(15'h10, 15'd16, 16'h00F0, -1, lat);
      chk("t5_rerun_pass", {pass, tmo_flag, errcnt}, {1'b1, 1'b0, 15'd0});
      post(15'h10, 16, 16'h00F0, 64);

      // Zero-length test.
      run(15'h5, 15'd0, 16'h0011, -1, lat);
      chk("t6_cnt0_latency", lat, 2);
      chk("t6_cnt0_pass", pass, 1);
      post(15'h5, 0, 16'h0011, 0);

      // start while busy is ignored (inputs scrambled at that moment).
      run(15'd3, 15'd4, 16'h0BAD, 4, lat);
      chk("t6_glitch_latency", lat, 18);
      chk("t6_glitch_pass", pass, 1);
      post(15'd3, 4, 16'h0BAD, 16);

      // Address wrap from the top of the space, seed 0 treated as 1.
      run(15'h7FFE, 15'd4, 16'h0000, -1, lat);
      chk("t6_wrap_pass", pass, 1);
      post(15'h7FFE, 4, 16'h0000, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
